// File: rtl/mcycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// write-back, and emits datapath selects and enables for the current state.
module mcycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       br_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_src,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic [1:0] alu_a_sel,
   output logic       alu_b_sel,
   output logic [1:0] alu_op,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       instret,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_WB     = 4'd6,
      S_JUMP   = 4'd7,
      S_BRANCH = 4'd8,
      S_TRAP   = 4'd9
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t r_state;
   state_t w_next;
   logic   r_illegal;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP) r_illegal <= 1'b1;
      end
   end

   // NOTE: every output and w_next gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      w_next    = r_state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_src   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'b00;
      alu_a_sel = 2'b00;
      alu_b_sel = 1'b0;
      alu_op    = 2'b00;
      rf_we     = 1'b0;
      wb_sel    = 2'b00;
      instret   = 1'b0;

      unique case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (opcode)
               OP_LUI, OP_AUIPC, OP_IMM, OP_REG: w_next = S_EXEC;
               OP_LOAD, OP_STORE:                w_next = S_MEMADR;
               OP_JAL, OP_JALR:                  w_next = S_JUMP;
               OP_BRANCH:                        w_next = S_BRANCH;
               default:                          w_next = S_TRAP;
            endcase
         end
         S_EXEC: begin
            w_next = S_WB;
            unique case (opcode)
               OP_LUI:   begin alu_a_sel = 2'b10; alu_b_sel = 1'b1; end
               OP_AUIPC: begin alu_a_sel = 2'b01; alu_b_sel = 1'b1; end
               OP_IMM:   begin alu_b_sel = 1'b1;  alu_op = 2'b01; end
               default:  alu_op = 2'b01;
            endcase
         end
         S_MEMADR: begin
            alu_b_sel = 1'b1;
            w_next    = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            alu_b_sel = 1'b1;
            mem_req   = 1'b1;
            mem_src   = 1'b1;
            if (mem_ready) w_next = S_WB;
         end
         S_MEMWR: begin
            alu_b_sel = 1'b1;
            mem_req   = 1'b1;
            mem_src   = 1'b1;
            mem_we    = 1'b1;
            if (mem_ready) begin
               pc_we   = 1'b1;
               instret = 1'b1;
               w_next  = S_FETCH;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            instret = 1'b1;
            wb_sel  = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
            w_next  = S_FETCH;
         end
         S_JUMP: begin
            rf_we     = 1'b1;
            wb_sel    = 2'b10;
            pc_we     = 1'b1;
            instret   = 1'b1;
            alu_b_sel = 1'b1;
            pc_src    = (opcode == OP_JALR) ? 2'b10 : 2'b01;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_op  = 2'b10;
            pc_we   = 1'b1;
            instret = 1'b1;
            pc_src  = br_taken ? 2'b01 : 2'b00;
            w_next  = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
   end

   assign illegal = r_illegal;
   assign state   = r_state;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Bench for mcycle_ctrl: an instruction-path model checked every cycle, plus
// directed instruction runs with hand-computed latencies and output values.
module tb_mcycle_ctrl;

   typedef enum logic [3:0] {
      T_FETCH = 4'd0, T_DECODE = 4'd1, T_EXEC = 4'd2, T_MEMADR = 4'd3,
      T_MEMRD = 4'd4, T_MEMWR = 4'd5, T_WB = 4'd6, T_JUMP = 4'd7,
      T_BRANCH = 4'd8, T_TRAP = 4'd9
   } st_e;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_src;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic [1:0] alu_a_sel;
      logic       alu_b_sel;
      logic [1:0] alu_op;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       instret;
      logic       illegal;
      logic [3:0] state;
   } outs_t;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, ADDI = 7'b0010011;
   localparam logic [6:0] ALU = 7'b0110011, LOAD = 7'b0000011, STORE = 7'b0100011;
   localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic br_taken = 1'b0;
   logic mem_ready = 1'b0;
   logic mem_req, mem_we, mem_src, ir_we, pc_we, alu_b_sel, rf_we, instret, illegal;
   logic [1:0] pc_src, alu_a_sel, alu_op, wb_sel;
   logic [3:0] state;

   int n_checks = 0;
   int n_errors = 0;

   mcycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_src(mem_src), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
      .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .illegal(illegal),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic outs_t dut_outs();
      return '{mem_req, mem_we, mem_src, ir_we, pc_we, pc_src, alu_a_sel,
               alu_b_sel, alu_op, rf_we, wb_sel, instret, illegal, state};
   endfunction

   // Model: each instruction class walks a fixed list of steps; memory steps
   // linger until mem_ready, TRAP never leaves.
   function automatic st_e path_at(input int i, input logic [6:0] op);
      st_e p [0:4];
      p = '{T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP};
      case (op)
         LUI, AUIPC, ADDI, ALU: begin p[2] = T_EXEC; p[3] = T_WB; end
         LOAD:  begin p[2] = T_MEMADR; p[3] = T_MEMRD; p[4] = T_WB; end
         STORE: begin p[2] = T_MEMADR; p[3] = T_MEMWR; end
         JAL, JALR: p[2] = T_JUMP;
         BR:        p[2] = T_BRANCH;
         default:   p[2] = T_TRAP;
      endcase
      return p[i];
   endfunction

   function automatic int path_len(input logic [6:0] op);
      case (op)
         LUI, AUIPC, ADDI, ALU, STORE: return 4;
         LOAD:                         return 5;
         default:                      return 3;
      endcase
   endfunction

   function automatic outs_t exp_outs(input st_e s, input logic [6:0] op,
                                      input logic br, input logic rdy, input logic ill);
      outs_t o;
      o = '0;
      o.state   = s;
      o.illegal = ill;
      case (s)
         T_FETCH: begin o.mem_req = 1; o.ir_we = rdy; end
         T_EXEC: begin
            o.alu_b_sel = (op != ALU);
            o.alu_op    = (op == ADDI || op == ALU) ? 2'b01 : 2'b00;
            o.alu_a_sel = (op == LUI) ? 2'b10 : (op == AUIPC) ? 2'b01 : 2'b00;
         end
         T_MEMADR: o.alu_b_sel = 1;
         T_MEMRD:  begin o.alu_b_sel = 1; o.mem_req = 1; o.mem_src = 1; end
         T_MEMWR: begin
            o.alu_b_sel = 1; o.mem_req = 1; o.mem_src = 1; o.mem_we = 1;
            o.pc_we = rdy; o.instret = rdy;
         end
         T_WB: begin
            o.rf_we = 1; o.pc_we = 1; o.instret = 1;
            o.wb_sel = (op == LOAD) ? 2'b01 : 2'b00;
         end
         T_JUMP: begin
            o.rf_we = 1; o.wb_sel = 2'b10; o.pc_we = 1; o.instret = 1; o.alu_b_sel = 1;
            o.pc_src = (op == JAL) ? 2'b01 : 2'b10;
         end
         T_BRANCH: begin
            o.alu_op = 2'b10; o.pc_we = 1; o.instret = 1;
            o.pc_src = br ? 2'b01 : 2'b00;
         end
         default: ;
      endcase
      return o;
   endfunction

   int   m_idx   = 0;
   logic m_ill   = 1'b0;
   bit   m_valid = 1'b0;

   always @(negedge clk) begin
      st_e cur;
      cur = path_at(m_idx, opcode);
      if (m_valid)
         check("outputs", 32'(dut_outs()), 32'(exp_outs(cur, opcode, br_taken, mem_ready, m_ill)));
      if (!rst_n) begin
         m_idx   = 0;
         m_ill   = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid && cur != T_TRAP &&
                   !((cur == T_FETCH || cur == T_MEMRD || cur == T_MEMWR) && !mem_ready)) begin
         m_idx = (m_idx + 1 == path_len(opcode)) ? 0 : m_idx + 1;
         if (path_at(m_idx, opcode) == T_TRAP) m_ill = 1'b1;
      end
   end

   outs_t tr[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered at posedge+1 with the DUT in FETCH; returns the same way.
   task automatic run_instr(input string name, input logic [6:0] op, input int fw,
                            input int mw, input logic br, input int exp_lat);
      int  cyc = 0;
      int  f = fw;
      int  m = mw;
      bit  done = 0;
      opcode   = op;
      br_taken = br;
      tr.delete();
      while (!done && cyc < 40) begin
         if (mem_req) begin
            if (state == 4'd0) begin mem_ready = (f == 0); if (f > 0) f--; end
            else               begin mem_ready = (m == 0); if (m > 0) m--; end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         tr.push_back(dut_outs());
         cyc++;
         if (instret) done = 1;
         tick();
      end
      check({name, "_latency"}, cyc, exp_lat);
   endtask

   initial begin
      int bad;
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
      bad = 0;
   end

   initial begin
      int bad;
      repeat (2) tick();
      #1;
      check("reset_state", state, 0);
      check("reset_mem_req", mem_req, 1);
      check("reset_illegal", illegal, 0);
      check("reset_ir_we", ir_we, 0);
      rst_n = 1'b1;

      run_instr("addi", ADDI, 0, 0, 0, 4);
      check("addi_states", {tr[0].state, tr[1].state, tr[2].state, tr[3].state}, 16'h0126);
      check("addi_exec_sel", {tr[2].alu_b_sel, tr[2].alu_op}, 3'b101);
      check("addi_retire", {tr[3].rf_we, tr[3].instret}, 2'b11);

      run_instr("load", LOAD, 2, 2, 0, 9);
      check("load_wb_sel", {tr[8].state, tr[8].wb_sel}, {4'd6, 2'b01});
      check("load_memrd_src", {tr[5].mem_src, tr[6].mem_src, tr[7].mem_src, tr[7].state}, {3'b111, 4'd4});

      run_instr("br_taken", BR, 0, 0, 1, 3);
      check("br_taken_src", {tr[2].state, tr[2].pc_src}, {4'd8, 2'b01});
      run_instr("br_not", BR, 0, 0, 0, 3);
      check("br_not_src", {tr[2].state, tr[2].pc_src}, {4'd8, 2'b00});

      run_instr("jalr", JALR, 0, 0, 0, 3);
      check("jalr_out", {tr[2].state, tr[2].pc_src, tr[2].wb_sel, tr[2].rf_we}, {4'd7, 2'b10, 2'b10, 1'b1});
      run_instr("jal", JAL, 1, 0, 0, 4);
      check("jal_src", tr[3].pc_src, 2'b01);

      run_instr("store", STORE, 0, 0, 0, 4);
      check("store_wr", {tr[3].state, tr[3].mem_we, tr[3].pc_we}, {4'd5, 2'b11});
      run_instr("store_wait", STORE, 0, 3, 0, 7);
      run_instr("lui", LUI, 0, 0, 0, 4);
      check("lui_exec", {tr[2].alu_a_sel, tr[2].alu_b_sel, tr[2].alu_op}, 5'b10100);
      run_instr("auipc", AUIPC, 0, 0, 0, 4);
      check("auipc_exec", tr[2].alu_a_sel, 2'b01);
      run_instr("op", ALU, 1, 0, 0, 5);
      check("op_exec", {tr[3].alu_b_sel, tr[3].alu_op}, 3'b001);

      opcode    = 7'b1111111;
      mem_ready = 1'b1;
      tick();
      tick();
      #1;
      check("trap_entry", {state, illegal}, {4'd9, 1'b1});
      bad = 0;
      repeat (20) begin
         mem_ready = 1'($urandom_range(0, 1));
         tick();
         #1;
         if (state != 4'd9 || !illegal || mem_req || ir_we || pc_we || rf_we || instret) bad++;
      end
      check("trap_hold", bad, 0);
      rst_n = 1'b0;
      tick();
      #1;
      check("trap_reset", {state, illegal}, {4'd0, 1'b0});
      rst_n = 1'b1;

      opcode    = STORE;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      #1;
      check("abort_in_memwr", {state, mem_we}, {4'd5, 1'b1});
      rst_n = 1'b0;
      #1;
      check("abort_no_retire", {instret, pc_we}, 2'b00);
      tick();
      #1;
      check("abort_state", {state, instret, pc_we, ir_we}, {4'd0, 3'b000});
      rst_n = 1'b1;

      run_instr("addi_after", ADDI, 0, 0, 0, 4);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  sync active-low reset.
- opcode  in  7  IR[6:0], stable from DECODE through retire.
- br_taken  in  1  branch-compare result, valid in BRANCH.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1=write, 0=read.
- mem_src  out  1  address select: 0=PC, 1=ALU result.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  2  00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1.
- alu_a_sel  out  2  00=rs1, 01=PC, 10=zero.
- alu_b_sel  out  1  0=rs2, 1=immediate.
- alu_op  out  2  00=add, 01=funct-decoded, 10=branch compare.
- rf_we  out  1  register-file write.
- wb_sel  out  2  00=ALU, 01=load data, 10=PC+4.
- instret  out  1  one-cycle retire pulse.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  4  current state encoding (debug).

Function
REQ-003 SHALL implement one registered FSM; state encodings: FETCH=0, DECODE=1, EXEC=2, MEMADR=3, MEMRD=4, MEMWR=5, WB=6, JUMP=7, BRANCH=8, TRAP=9.
REQ-004 All outputs SHALL be combinational from registered state, opcode, br_taken and mem_ready; any output not listed for a state SHALL be 0.
REQ-005 FETCH SHALL drive mem_req=1 and mem_src=0, hold there while mem_ready=0, and on mem_ready=1 drive ir_we=1 and go to DECODE.
REQ-006 DECODE SHALL last one cycle and route by opcode:
- 0110111, 0010111, 0010011, 0110011 -> EXEC.
- 0000011, 0100011 -> MEMADR.
- 1101111, 1100111 -> JUMP.
- 1100011 -> BRANCH.
- any other opcode -> TRAP.
REQ-007 EXEC SHALL select by opcode, then go to WB:
- LUI: alu_a_sel=10, alu_b_sel=1, alu_op=00.
- AUIPC: alu_a_sel=01, alu_b_sel=1, alu_op=00.
- OP-IMM: alu_a_sel=00, alu_b_sel=1, alu_op=01.
- OP: alu_a_sel=00, alu_b_sel=0, alu_op=01.
REQ-008 MEMADR SHALL drive alu_a_sel=00, alu_b_sel=1, alu_op=00, then go to MEMRD (load) or MEMWR (store).
REQ-009 MEMRD SHALL hold the MEMADR ALU selects and drive mem_req=1, mem_src=1, mem_we=0, staying while mem_ready=0, then go to WB.
REQ-010 MEMWR SHALL hold the MEMADR ALU selects and drive mem_req=1, mem_src=1, mem_we=1; on mem_ready=1 it SHALL also drive pc_we=1, pc_src=00, instret=1 and go to FETCH.
REQ-011 WB SHALL drive rf_we=1, pc_we=1, pc_src=00 and instret=1, with wb_sel=01 for a load and 00 otherwise, then go to FETCH.
REQ-012 JUMP SHALL drive rf_we=1, wb_sel=10, pc_we=1, instret=1 and alu_b_sel=1, with pc_src=01 for JAL and 10 for JALR, then go to FETCH.
REQ-013 BRANCH SHALL drive alu_op=10, alu_b_sel=0, pc_we=1, instret=1 and pc_src=01 if br_taken=1 else 00, then go to FETCH.
REQ-014 TRAP SHALL hold illegal=1, keep every enable (mem_req, ir_we, pc_we, rf_we, instret) at 0, and stay in TRAP until reset.
REQ-015 Retire latency with zero-wait memory (mem_ready=1 on first request cycle) SHALL be:
- ALU/LUI/AUIPC: 4 cycles.
- load: 5 cycles.
- store: 4 cycles.
- jump/branch: 3 cycles.
Each wait cycle on mem_ready SHALL add exactly one cycle.
REQ-016 mem_ready SHALL be ignored whenever mem_req=0, and mem_req SHALL stay continuously asserted from first assertion until the mem_ready cycle.
REQ-017 Exactly one instret pulse SHALL occur per retired instruction, and never in FETCH, DECODE, EXEC, MEMADR, MEMRD or TRAP.

Reset
REQ-018 When rst_n=0 at a rising edge, state SHALL become FETCH and illegal SHALL clear; all outputs then follow FETCH (mem_req=1, mem_src=0, others 0).
REQ-019 Reset asserted mid-request SHALL abandon the transaction; no ir_we, pc_we, rf_we or instret SHALL be issued for it.

Verification
REQ-020 Bench SHALL cover:
- ADDI (0010011), mem_ready=1 always -> states 0,1,2,6; rf_we=1 and instret=1 on cycle 4; alu_b_sel=1, alu_op=01 in EXEC.
- Load, mem_ready low 2 cycles in both FETCH and MEMRD -> 9-cycle retire; wb_sel=01 in WB; mem_src=1 throughout MEMRD.
- Branch with br_taken=1 then br_taken=0 -> pc_src=01 then 00, each retiring in 3 cycles.
- JALR -> JUMP state: pc_src=10, wb_sel=10, rf_we=1.
- Opcode 1111111 -> TRAP, illegal=1 held 20 cycles with no enables; rst_n=0 one cycle -> state=0, illegal=0.
- rst_n=0 during MEMWR with mem_ready=0 -> no instret and no pc_we; next cycle state=FETCH.
